// File: rtl/dmem_access_unit.sv
// Load/store front-end for a word-addressed data memory: big-endian sub-word
// extraction with sign/zero extension, read-modify-write for SB/SH, misalign detection.
module dmem_access_unit #(
    parameter int unsigned WORD_ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_op,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_misalign,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_misalign;
    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [31:0] r_mem_wdata;

    logic        w_misalign;
    logic [31:0] w_word_idx;
    logic        w_unused_addr;

    // Big-endian lane extraction with sign/zero extension
    function automatic logic [31:0] f_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (op)
            OP_LB:   f_load = {{24{b[7]}}, b};
            OP_LBU:  f_load = {24'd0, b};
            OP_LH:   f_load = {{16{h[15]}}, h};
            OP_LHU:  f_load = {16'd0, h};
            default: f_load = w;
        endcase
    endfunction

    // Splice the store lane into the word read back from memory
    function automatic logic [31:0] f_merge(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] w, input logic [31:0] d);
        logic [31:0] m;
        m = w;
        if (op == OP_SB) begin
            case (off)
                2'd0:    m[31:24] = d[7:0];
                2'd1:    m[23:16] = d[7:0];
                2'd2:    m[15:8]  = d[7:0];
                default: m[7:0]   = d[7:0];
            endcase
        end else if (op == OP_SH) begin
            if (off[1]) m[15:0]  = d[15:0];
            else        m[31:16] = d[15:0];
        end else begin
            m = d;
        end
        return m;
    endfunction

    always_comb begin
        w_misalign = 1'b0;
        case (i_req_op)
            OP_LH, OP_LHU, OP_SH: w_misalign = i_req_addr[0];
            OP_LW, OP_SW:         w_misalign = |i_req_addr[1:0];
            default:              w_misalign = 1'b0;
        endcase
    end

    // Address bits above the word-index range alias
    assign w_word_idx    = 32'(i_req_addr[WORD_ADDR_BITS+1:2]);
    assign w_unused_addr = ^i_req_addr[31:WORD_ADDR_BITS+2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_op            <= OP_LB;
            r_off           <= 2'd0;
            r_wdata         <= 32'd0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= 32'd0;
            r_resp_misalign <= 1'b0;
            r_mem_addr      <= 32'd0;
            r_mem_we        <= 1'b0;
            r_mem_wdata     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_op            <= i_req_op;
                        r_off           <= i_req_addr[1:0];
                        r_wdata         <= i_req_wdata;
                        r_req_ready     <= 1'b0;
                        r_resp_misalign <= 1'b0;
                        if (w_misalign) begin
                            r_resp_misalign <= 1'b1;
                            r_resp_rdata    <= 32'd0;
                            r_resp_valid    <= 1'b1;
                            r_state         <= S_DONE;
                        end else begin
                            r_mem_addr <= w_word_idx;
                            if (i_req_op <= OP_LW) begin
                                r_state <= S_LOAD;
                            end else if (i_req_op == OP_SW) begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= i_req_wdata;
                                r_state     <= S_WRITE;
                            end else begin
                                r_state <= S_RMW;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_resp_rdata <= f_load(r_op, r_off, i_mem_rdata);
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_RMW: begin
                    r_mem_wdata <= f_merge(r_op, r_off, i_mem_rdata, r_wdata);
                    r_mem_we    <= 1'b1;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    r_mem_we     <= 1'b0;
                    r_resp_rdata <= 32'd0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready     = r_req_ready;
    assign o_resp_valid    = r_resp_valid;
    assign o_resp_rdata    = r_resp_rdata;
    assign o_resp_misalign = r_resp_misalign;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_we        = r_mem_we;
    assign o_mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: a reference memory and load/store model
// predict each response, its latency and any memory write.
module tb_dmem_access_unit;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          nwe;
        int          wlat;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        bd_en = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_val = 32'd0;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    dmem_access_unit #(.WORD_ADDR_BITS(16)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_misalign(resp_misalign),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_we)     mem[mem_addr[5:0]] <= mem_wdata;
        else if (bd_en) mem[bd_idx] <= bd_val;
    end

    function automatic logic m_mis(input logic [2:0] op, input logic [31:0] a);
        if (op == LH || op == LHU || op == SH) return a[0];
        if (op == LW || op == SW) return a[1:0] != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (3 - int'(off)))) & 32'hFF;
        h = (w >> (off[1] ? 0 : 16)) & 32'hFFFF;
        case (op)
            LB:      return b[7] ? (b | 32'hFFFFFF00) : b;
            LBU:     return b;
            LH:      return h[15] ? (h | 32'hFFFF0000) : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] w, input logic [31:0] d);
        int sh;
        logic [31:0] mask;
        if (op == SW) return d;
        sh   = (op == SB) ? 8 * (3 - int'(off)) : (off[1] ? 0 : 16);
        mask = ((op == SB) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        bd_en = 1'b1; bd_idx = 6'(idx); bd_val = val;
        @(posedge clk);
        #1 bd_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Drive one request (accepted at the next rising edge) and push its predicted outcome
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input bit hold);
        exp_t e;
        int   idx;
        idx = int'(addr[7:2]);
        e.rdata = 32'd0; e.mis = m_mis(op, addr); e.nwe = 0; e.wlat = 0;
        e.waddr = 32'(addr[17:2]); e.wdata = 32'd0;
        if (e.mis)          e.lat = 1;
        else if (op <= LW) begin e.lat = 2; e.rdata = m_load(op, addr[1:0], ref_mem[idx]); end
        else begin
            e.nwe   = 1;
            e.wlat  = (op == SW) ? 1 : 2;
            e.lat   = e.wlat + 1;
            e.wdata = m_store(op, addr[1:0], ref_mem[idx], wd);
            ref_mem[idx] = e.wdata;
        end
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 if (!hold) req_valid = 1'b0;
    endtask

    // Observe cycles after acceptance until a response, bounded
    task automatic collect(output bit got, output int lat, output logic [31:0] rd,
                           output logic mis, output int nwe, output int wlat,
                           output logic [31:0] waddr, output logic [31:0] wdata);
        got = 0; lat = 0; rd = 'x; mis = 'x; nwe = 0; wlat = 0; waddr = 'x; wdata = 'x;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we) begin nwe++; wlat = c; waddr = mem_addr; wdata = mem_wdata; end
            if (resp_valid) begin got = 1; lat = c; rd = resp_rdata; mis = resp_misalign; break; end
        end
    endtask

    task automatic run_table(input string name, input logic [2:0] ops[],
                             input logic [31:0] addrs[], input logic [31:0] wds[],
                             input logic [31:0] pre);
        bit got; int lat, nwe, wlat; logic [31:0] rd, waddr, wdata; logic mis;
        exp_t e;
        for (int i = 0; i < ops.size(); i++) begin
            preload(5, pre);
            send(ops[i], addrs[i], wds[i], 1'b0);
            collect(got, lat, rd, mis, nwe, wlat, waddr, wdata);
            e = exp_q.pop_front();
            n_cmp++;
            if (!got || lat != e.lat) begin
                n_fail++;
                $display("FAIL %s[%0d] latency: got %0d (resp=%0b) want %0d", name, i, lat, got, e.lat);
            end
            n_cmp++;
            if (rd !== e.rdata || mis !== e.mis) begin
                n_fail++;
                $display("FAIL %s[%0d] resp: got rdata=%h mis=%b want rdata=%h mis=%b",
                         name, i, rd, mis, e.rdata, e.mis);
            end
            n_cmp++;
            if (nwe != e.nwe || (e.nwe == 1 && (wlat != e.wlat || waddr !== e.waddr || wdata !== e.wdata))) begin
                n_fail++;
                $display("FAIL %s[%0d] write: got n=%0d lat=%0d addr=%h data=%h want n=%0d lat=%0d addr=%h data=%h",
                         name, i, nwe, wlat, waddr, wdata, e.nwe, e.wlat, e.waddr, e.wdata);
            end
            @(negedge clk);
            n_cmp++;
            if (mem[5] !== ref_mem[5]) begin
                n_fail++;
                $display("FAIL %s[%0d] memory word 5: got %h want %h", name, i, mem[5], ref_mem[5]);
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({req_ready, resp_valid, resp_misalign, mem_we} !== 4'b1000 ||
            resp_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b rv=%b mis=%b we=%b rd=%h ma=%h wd=%h want 1 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_misalign, mem_we, resp_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_loads();
        run_table("lw", '{LW}, '{32'h14}, '{32'h0}, 32'h11223344);
        run_table("subword_load", '{LB, LBU, LH, LH, LHU, LB},
                  '{32'h15, 32'h15, 32'h16, 32'h14, 32'h14, 32'h17},
                  '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 32'h80FF7F01);
        // Upper address bits alias onto the same word
        run_table("alias", '{LW}, '{32'h8004_0014}, '{32'h0}, 32'h5A5A_1234);
    endtask

    task automatic test_stores();
        run_table("sub_store", '{SB, SH, SB, SH},
                  '{32'h16, 32'h14, 32'h14, 32'h16},
                  '{32'hAB, 32'hBEEF, 32'hFFFF_FF77, 32'h1234_5678}, 32'h11223344);
        run_table("sw", '{SW}, '{32'h14}, '{32'hDEAD_BEEF}, 32'h11223344);
    endtask

    task automatic test_misalign();
        // Preceding LB leaves resp_rdata nonzero so the cleared value is visible
        run_table("misalign", '{LB, SW, LH, LW, SH, LBU},
                  '{32'h14, 32'h13, 32'h15, 32'h16, 32'h17, 32'h14},
                  '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hAAAA, 32'h0}, 32'h9988_7766);
    endtask

    task automatic test_reset_mid();
        logic [31:0] saved;
        int bad;
        preload(5, 32'h11223344);
        saved = ref_mem[5];
        send(SB, 32'h16, 32'hAB, 1'b0);
        void'(exp_q.pop_back());
        ref_mem[5] = saved;
        #2 reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_we || resp_valid) bad++;
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_we || resp_valid) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_mid_activity: got %0d cycles with we/resp want 0", bad);
        end
        n_cmp++;
        if (req_ready !== 1'b1 || mem[5] !== saved) begin
            n_fail++;
            $display("FAIL reset_mid_state: got rdy=%b mem=%h want rdy=1 mem=%h", req_ready, mem[5], saved);
        end
    endtask

    task automatic test_back_to_back();
        int nwe, nresp;
        exp_t e;
        preload(8, 32'h0);
        send(SW, 32'h20, 32'hCAFE_F00D, 1'b1);
        req_op = LW; req_wdata = 32'h0;
        // Pre-compute the load result the model expects after the store
        e.rdata = m_load(LW, 2'd0, ref_mem[8]); e.mis = 1'b0; e.lat = 5;
        e.nwe = 0; e.wlat = 0; e.waddr = 32'd8; e.wdata = 32'd0;
        exp_q.push_back(e);
        nwe = 0; nresp = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_we) begin
                nwe++;
                n_cmp++;
                if (c != 1 || mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'd8) begin
                    n_fail++;
                    $display("FAIL b2b_write: got cycle=%0d addr=%h data=%h want cycle=1 addr=8 data=cafef00d",
                             c, mem_addr, mem_wdata);
                end
            end
            if (resp_valid) begin
                nresp++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL b2b_extra_resp: got response at cycle %0d want none", c);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (c != e.lat || resp_rdata !== e.rdata || resp_misalign !== e.mis) begin
                        n_fail++;
                        $display("FAIL b2b_resp: got cycle=%0d rdata=%h mis=%b want cycle=%0d rdata=%h mis=%b",
                                 c, resp_rdata, resp_misalign, e.lat, e.rdata, e.mis);
                    end
                end
            end
            if (req_ready && req_valid) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        n_cmp++;
        if (nwe != 1 || nresp != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got writes=%0d resps=%0d want writes=1 resps=2", nwe, nresp);
        end
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        preload(8, 32'h0);
        test_loads();
        test_stores();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Initial memory contents are don't-care until preloaded; start from zero
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    end

endmodule
